// File: rtl/serial_adder_operand_serializer.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_operand_serializer
// Description : Converts a parallel operand pair into an LSB-first bit-pair
//               stream that feeds the serial adder; pause holds position.
//               SERIAL_ADDER_SERIALIZER_PREFETCH_EN adds a one-entry hold buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_operand_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             pause,
    output logic             vld,
    output logic             a,
    output logic             b,
    output logic             last,
    output logic             busy
);
    localparam int            CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
    localparam logic [0:0]    ST_IDLE    = 1'b0;
    localparam logic [0:0]    ST_SHIFT   = 1'b1;

    logic [0:0]       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sh_a, r_sh_b, w_sh_a_nxt, w_sh_b_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             w_shift, w_emit, w_emit_last, w_accept;

    assign w_shift     = (r_state == ST_SHIFT);
    assign w_emit      = w_shift && !pause;
    assign w_emit_last = w_emit && (r_cnt == C_CNT_LAST);
    assign w_accept    = in_vld && in_ready;

    assign vld  = w_emit;
    assign a    = w_shift & r_sh_a[0];
    assign b    = w_shift & r_sh_b[0];
    assign last = w_emit_last;
    assign busy = w_shift;

`ifdef SERIAL_ADDER_SERIALIZER_PREFETCH_EN
    logic             r_hold_full, w_hold_full_nxt;
    logic [WIDTH-1:0] r_hold_a, r_hold_b, w_hold_a_nxt, w_hold_b_nxt;

    assign in_ready = !r_hold_full;

    always_comb begin
        w_state_nxt     = r_state;
        w_sh_a_nxt      = r_sh_a;
        w_sh_b_nxt      = r_sh_b;
        w_cnt_nxt       = r_cnt;
        w_hold_full_nxt = r_hold_full;
        w_hold_a_nxt    = r_hold_a;
        w_hold_b_nxt    = r_hold_b;
        if (w_emit) begin
            w_sh_a_nxt = r_sh_a >> 1;
            w_sh_b_nxt = r_sh_b >> 1;
            w_cnt_nxt  = w_emit_last ? '0 : r_cnt + C_CNT_ONE;
        end
        // The shifter is free this edge: refill from hold first, then input.
        if (!w_shift || w_emit_last) begin
            if (w_emit_last && r_hold_full) begin
                w_sh_a_nxt      = r_hold_a;
                w_sh_b_nxt      = r_hold_b;
                w_cnt_nxt       = '0;
                w_hold_full_nxt = 1'b0;
                w_state_nxt     = ST_SHIFT;
            end else if (w_accept) begin
                w_sh_a_nxt  = in_a;
                w_sh_b_nxt  = in_b;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_SHIFT;
            end else if (w_emit_last) begin
                w_state_nxt = ST_IDLE;
            end
        end else if (w_accept) begin
            w_hold_a_nxt    = in_a;
            w_hold_b_nxt    = in_b;
            w_hold_full_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_full <= 1'b0;
            r_hold_a    <= '0;
            r_hold_b    <= '0;
        end else begin
            r_hold_full <= w_hold_full_nxt;
            r_hold_a    <= w_hold_a_nxt;
            r_hold_b    <= w_hold_b_nxt;
        end
    end
`else
    assign in_ready = !w_shift;

    always_comb begin
        w_state_nxt = r_state;
        w_sh_a_nxt  = r_sh_a;
        w_sh_b_nxt  = r_sh_b;
        w_cnt_nxt   = r_cnt;
        if (!w_shift && w_accept) begin
            w_sh_a_nxt  = in_a;
            w_sh_b_nxt  = in_b;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_SHIFT;
        end else if (w_emit) begin
            w_sh_a_nxt = r_sh_a >> 1;
            w_sh_b_nxt = r_sh_b >> 1;
            w_cnt_nxt  = w_emit_last ? '0 : r_cnt + C_CNT_ONE;
            if (w_emit_last) begin
                w_state_nxt = ST_IDLE;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sh_a  <= w_sh_a_nxt;
            r_sh_b  <= w_sh_b_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_operand_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_operand_serializer
// Description : Directed bench for the operand serializer at WIDTH 4, 1 and 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_operand_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       iv4 = 1'b0, p4 = 1'b0, rdy4, v4, a4, b4, l4, busy4;
    logic [3:0] ia4 = '0, ib4 = '0;
    logic       iv1 = 1'b0, p1 = 1'b0, rdy1, v1, a1, b1, l1, busy1;
    logic [0:0] ia1 = '0, ib1 = '0;
    logic       iv8 = 1'b0, p8 = 1'b0, rdy8, v8, a8, b8, l8, busy8;
    logic [7:0] ia8 = '0, ib8 = '0;

    int total = 0;
    int bad   = 0;

    logic [4:0] e4 [1:10];
    logic [4:0] e1 [1:4];
    logic [3:0] ea, eb;
    logic       acc, carry;
    logic [7:0] sum_bits, a_bits;
    int         nw, j, n, last_pos;

    always #5 clk = ~clk;

    serial_adder_operand_serializer #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .in_vld(iv4), .in_ready(rdy4), .in_a(ia4), .in_b(ib4),
        .pause(p4), .vld(v4), .a(a4), .b(b4), .last(l4), .busy(busy4));
    serial_adder_operand_serializer #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_vld(iv1), .in_ready(rdy1), .in_a(ia1), .in_b(ib1),
        .pause(p1), .vld(v1), .a(a1), .b(b1), .last(l1), .busy(busy1));
    serial_adder_operand_serializer #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_vld(iv8), .in_ready(rdy8), .in_a(ia8), .in_b(ib8),
        .pause(p8), .vld(v8), .a(a8), .b(b8), .last(l8), .busy(busy8));

    task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    // Return to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        tick(); tick(); tick();
        #1;
        chk("rst_out4", 0, {v4, a4, b4, l4, busy4, rdy4}, 6'b000001);
        chk("rst_out1", 0, {v1, a1, b1, l1, busy1, rdy1}, 6'b000001);
        chk("rst_out8", 0, {v8, a8, b8, l8, busy8, rdy8}, 6'b000001);
        tick();
        rst = 1'b0;

        // Basic word
        ea = 4'b1011; eb = 4'b0110;
        iv4 = 1'b1; ia4 = ea; ib4 = eb;
        tick();
        iv4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("basic", k, {v4, a4, b4, l4}, {1'b1, ea[k], eb[k], k == 3});
            tick();
        end
        #1;
        chk("basic_end", 0, {v4, l4, busy4, rdy4}, 4'b0001);
        tick();

        // Pause in cycles 2 and 3 after accept
        iv4 = 1'b1; ia4 = ea; ib4 = eb;
        tick();
        iv4 = 1'b0;
        j = 0;
        for (int k = 1; k <= 6; k++) begin
            p4 = (k == 2 || k == 3);
            #1;
            if (p4) begin
                chk("pause_hold", k, {v4, l4, busy4}, 3'b001);
            end else begin
                chk("pause_bits", k, {v4, a4, b4, l4}, {1'b1, ea[j], eb[j], j == 3});
                j++;
            end
            tick();
        end
        p4 = 1'b0;
        #1;
        chk("pause_end", 0, {v4, busy4}, 2'b00);
        tick();

        // Back-to-back words with in_vld held high
`ifdef SERIAL_ADDER_SERIALIZER_PREFETCH_EN
        e4 = '{5'b11101, 5'b11000, 5'b11000, 5'b11010, 5'b11001,
               5'b11101, 5'b10001, 5'b10011, 5'b00001, 5'b00001};
`else
        e4 = '{5'b11100, 5'b11000, 5'b11000, 5'b11010, 5'b00001,
               5'b11000, 5'b11100, 5'b10000, 5'b10010, 5'b00001};
`endif
        nw = 0;
        iv4 = 1'b1; ia4 = 4'hF; ib4 = 4'h1;
        for (int c = 0; c <= 10; c++) begin
            #1;
            if (c > 0) chk("b2b_w4", c, {v4, a4, b4, l4, rdy4}, e4[c]);
            acc = iv4 && rdy4;
            tick();
            if (acc) begin
                nw++;
                if (nw == 1) begin
                    ia4 = 4'h3; ib4 = 4'h2;
                end else begin
                    iv4 = 1'b0;
                end
            end
        end

        // Reset mid-word after two emitted bits
        iv4 = 1'b1; ia4 = ea; ib4 = eb;
        tick();
        iv4 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rst_mid_bits", k, {v4, a4, b4, l4}, {1'b1, ea[k], eb[k], 1'b0});
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_out", 0, {v4, l4, busy4, rdy4}, 4'b0001);
        tick();
        // Reset wins over a same-edge accept
        rst = 1'b1; iv4 = 1'b1;
        tick();
        rst = 1'b0; iv4 = 1'b0;
        #1;
        chk("rst_vs_accept", 0, {v4, busy4, rdy4}, 3'b001);
        tick();
        ea = 4'b0101; eb = 4'b1100;
        iv4 = 1'b1; ia4 = ea; ib4 = eb;
        tick();
        iv4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("post_rst", k, {v4, a4, b4, l4}, {1'b1, ea[k], eb[k], k == 3});
            tick();
        end

        // WIDTH=1 back-to-back
`ifdef SERIAL_ADDER_SERIALIZER_PREFETCH_EN
        e1 = '{5'b11111, 5'b10111, 5'b00001, 5'b00001};
`else
        e1 = '{5'b11110, 5'b00001, 5'b10110, 5'b00001};
`endif
        nw = 0;
        iv1 = 1'b1; ia1 = 1'b1; ib1 = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            #1;
            if (c > 0) chk("b2b_w1", c, {v1, a1, b1, l1, rdy1}, e1[c]);
            acc = iv1 && rdy1;
            tick();
            if (acc) begin
                nw++;
                if (nw == 1) begin
                    ia1 = 1'b0; ib1 = 1'b1;
                end else begin
                    iv1 = 1'b0;
                end
            end
        end

        // End-to-end through a serial adder model: A5 + 5B
        iv8 = 1'b1; ia8 = 8'hA5; ib8 = 8'h5B;
        tick();
        iv8 = 1'b0;
        carry = 1'b0; n = 0; last_pos = -1; sum_bits = '0; a_bits = '0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (v8 && n < 8) begin
                sum_bits[n] = a8 ^ b8 ^ carry;
                a_bits[n]   = a8;
                if (l8) last_pos = n;
                carry = l8 ? 1'b0 : ((a8 & b8) | (a8 & carry) | (b8 & carry));
                n++;
            end
            tick();
        end
        chk("e2e_count", 0, n, 8);
        chk("e2e_sum", 0, sum_bits, 8'h00);
        chk("e2e_a_bits", 0, a_bits, 8'hA5);
        chk("e2e_last_pos", 0, last_pos, 7);
        chk("e2e_carry", 0, carry, 1'b0);
        chk("e2e_idle", 0, {v8, busy8, rdy8}, 3'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder_operand_serializer.md
# serial_adder_operand_serializer

Upstream stage of the serial adder. Accepts a pair of parallel operands through a valid/ready handshake and emits them LSB-first, one bit pair per clock. It drives the adder's `vld`, `a`, `b` and `last` inputs directly. A downstream `pause` input suppresses bit emission without losing position in the word.

## Interface

- `WIDTH`, default 8, operand width in bits, must be ≥ 1.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `in_vld`: input, 1 bit. A parallel operand pair is offered.
- `in_ready`: output, 1 bit. The block can accept the offered pair this cycle.
- `in_a`: input, `WIDTH` bits. Operand A.
- `in_b`: input, `WIDTH` bits. Operand B.
- `pause`: input, 1 bit. Downstream stall; no bit is emitted this cycle.
- `vld`: output, 1 bit. `a`/`b`/`last` carry a valid bit pair.
- `a`: output, 1 bit. Current bit of A.
- `b`: output, 1 bit. Current bit of B.
- `last`: output, 1 bit. Current pair is the MSB of the word.
- `busy`: output, 1 bit. A word is in the shifter.

Clock `clk`; reset `rst` is synchronous, active-high.

## Operation

- Handshake: a word is accepted when `in_vld && in_ready` at a rising edge. `in_a`/`in_b` are sampled only at that edge.
- States:
  - IDLE: shifter empty.
  - SHIFT: shifter holds a word and bit counter `cnt` (0..WIDTH-1).
- IDLE → SHIFT: on accept. Load the shift registers from the accepted (or held, see Configuration) pair and set `cnt = 0`.
- Emission in SHIFT:
  - `vld = !pause`.
  - `a = sh_a[0]`, `b = sh_b[0]`.
  - `last = vld && (cnt == WIDTH-1)`.
- An emitted bit (SHIFT and `vld`) shifts both registers right by one and increments `cnt`.
- Pause: with `pause` high in SHIFT, `vld = 0`, `last = 0`, and the registers and `cnt` hold. `a`/`b` are don't-care.
- End of word: emitting with `cnt == WIDTH-1` leaves SHIFT. The block goes to IDLE, or reloads from the hold buffer (Configuration).
- Outside SHIFT: `vld`, `a`, `b`, `last` are all 0.
- `busy = (state == SHIFT)`.
- WIDTH = 1: every emitted pair has `last = 1`, and each word occupies SHIFT for exactly one emitting cycle.
- Reset:
  - Takes priority over everything, including an accept in the same cycle.
  - Discards any partial word; no `last` is produced for it.
  - Clears the hold buffer.
- Counter width is `max(1, $clog2(WIDTH))`. `cnt` never exceeds WIDTH-1.

## Timing

- Reset values: state IDLE, `cnt = 0`, hold empty, `vld = a = b = last = busy = 0`, `in_ready = 1`.
- Latency: a word accepted at edge N presents bit 0 in cycle N+1 (`vld = 1` unless paused).
- Word duration: WIDTH emitting cycles plus one cycle per paused cycle.
- `vld`, `last`, `a`, `b` are combinational from registered state and `pause`. No other input reaches an output combinationally.
- `in_ready` depends only on registered state, never on `in_vld`.

## Configuration

- Macro: `SERIAL_ADDER_SERIALIZER_PREFETCH_EN`.
- Without the macro:
  - `in_ready = (state == IDLE)`.
  - Back-to-back words leave one idle cycle (`vld = 0`) between the `last` of word K and bit 0 of word K+1.
  - Throughput is WIDTH+1 cycles per word.
- With the macro, a one-entry hold buffer (A, B, full flag) is added:
  - `in_ready = !hold_full`.
  - An accepted word goes straight into the shifter if the state is IDLE, or if SHIFT is emitting its last bit this cycle. Otherwise it goes into the hold buffer.
  - On emitting `last` with the hold buffer full, the hold contents load into the shifter in the same edge, with `cnt = 0`, and the buffer empties. Bit 0 of the next word appears in the very next cycle.
  - Throughput is WIDTH cycles per word.
  - Reset clears the hold buffer.

## Test plan

- Basic word: WIDTH=4, accept `in_a = 4'b1011`, `in_b = 4'b0110`, `pause = 0`. Next 4 cycles: `a` = 1,1,0,1; `b` = 0,1,1,0; `vld = 1`; `last` = 0,0,0,1. Then `vld = 0` and `in_ready = 1`.
- Pause mid-word: same word, `pause` high in cycles 2–3 after accept. `vld = 0` in those cycles; the bit sequence is unchanged and `last` falls on the 6th cycle after accept.
- Back-to-back: `in_vld` held high with words 4'hF/4'h1, then 4'h3/4'h2.
  - Without macro: one `vld = 0` cycle between words.
  - With macro: second word's bit 0 (a = 1, b = 0) directly follows `last`; `in_ready` drops to 0 while the hold buffer is full.
- Reset mid-word: assert `rst` after 2 emitted bits. Next cycle `vld = last = busy = 0` and `in_ready = 1`; a new word then serializes from bit 0.
- WIDTH=1: words 1/1 and 0/1 back-to-back. Each emits a single pair with `last = 1`; bubble count between them is as in the back-to-back scenario.
- End-to-end: feed the serial adder with 8'hA5 + 8'h5B. The sum bits collected LSB-first equal 8'h00, and the adder carry is cleared after `last`.
